// File: rtl/match_timer_if.sv
// Controller-to-timer bundle: the game state and pause go in; the timeout level,
// the warning, the tick pulse and the BCD display digits come back.
interface match_timer_if;
    logic [2:0] state;
    logic       pause;
    logic       time_up;
    logic       warn;
    logic       sec_tick;
    logic [3:0] min_bcd;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;

    modport master (
        output state,
        output pause,
        input  time_up,
        input  warn,
        input  sec_tick,
        input  min_bcd,
        input  sec_tens,
        input  sec_ones
    );

    modport slave (
        input  state,
        input  pause,
        output time_up,
        output warn,
        output sec_tick,
        output min_bcd,
        output sec_tens,
        output sec_ones
    );
endinterface

// File: rtl/match_timer.sv
// Countdown match clock: BCD M:SS digits counted down once per CLK_HZ cycles while
// the game is running, with a sticky time_up level and a low-time warning.
module match_timer #(
    parameter int CLK_HZ    = 100000000,
    parameter int MATCH_SEC = 120,
    parameter int WARN_SEC  = 10
) (
    input  logic          clk,
    input  logic          rst,
    match_timer_if.slave  tmr
);

    // Game-state codes shared with the controller
    localparam logic [2:0] STATE_READY   = 3'd0;
    localparam logic [2:0] STATE_GAME    = 3'd1;
    localparam logic [2:0] STATE_P1_WINS = 3'd2;
    localparam logic [2:0] STATE_P2_WINS = 3'd3;
    localparam logic [2:0] STATE_1P_GAME = 3'd4;
    localparam logic [2:0] STATE_1P_OVER = 3'd5;

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    localparam logic [3:0] RELOAD_MIN  = 4'(MATCH_SEC / 60);
    localparam logic [3:0] RELOAD_TENS = 4'((MATCH_SEC % 60) / 10);
    localparam logic [3:0] RELOAD_ONES = 4'(MATCH_SEC % 10);
    localparam logic [9:0] WARN_LIMIT  = 10'(WARN_SEC);

    typedef enum logic [1:0] {
        MODE_LOAD,
        MODE_RUN,
        MODE_FREEZE
    } mode_e;

    logic [3:0]    min_q, min_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          time_up_q, time_up_d;
    logic          warn_q, warn_d;
    logic          sec_tick_q, sec_tick_d;

    mode_e         mode;
    logic          tick;

    function automatic logic [9:0] secs_left(input logic [3:0] m,
                                             input logic [3:0] t,
                                             input logic [3:0] o);
        return 10'(m) * 10'd60 + 10'(t) * 10'd10 + 10'(o);
    endfunction

    always_comb begin
        unique case (tmr.state)
            STATE_READY:                mode = MODE_LOAD;
            STATE_GAME, STATE_1P_GAME:  mode = MODE_RUN;
            default:                    mode = MODE_FREEZE;
        endcase
    end

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves one unassigned (no latch).
        min_d      = min_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        presc_d    = presc_q;
        time_up_d  = time_up_q;
        warn_d     = 1'b0;
        sec_tick_d = 1'b0;
        tick       = 1'b0;

        unique case (mode)
            MODE_LOAD: begin
                min_d     = RELOAD_MIN;
                tens_d    = RELOAD_TENS;
                ones_d    = RELOAD_ONES;
                presc_d   = '0;
                time_up_d = 1'b0;
            end

            MODE_RUN: begin
                if (!tmr.pause && !time_up_q) begin
                    if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        tick    = 1'b1;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end

                if (tick) begin
                    sec_tick_d = 1'b1;
                    if (ones_q != 4'd0) begin
                        ones_d = ones_q - 4'd1;
                    end else begin
                        ones_d = 4'd9;
                        if (tens_q != 4'd0) begin
                            tens_d = tens_q - 4'd1;
                        end else begin
                            tens_d = 4'd5;
                            min_d  = min_q - 4'd1;
                        end
                    end
                    if (min_d == 4'd0 && tens_d == 4'd0 && ones_d == 4'd0)
                        time_up_d = 1'b1;
                end

                // Judged on the next digits so warn moves on the same edge as the display
                warn_d = (secs_left(min_d, tens_d, ones_d) <= WARN_LIMIT);
            end

            default: begin
                // FREEZE: everything holds, warn and sec_tick stay at their defaults
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            min_q      <= RELOAD_MIN;
            tens_q     <= RELOAD_TENS;
            ones_q     <= RELOAD_ONES;
            presc_q    <= '0;
            time_up_q  <= 1'b0;
            warn_q     <= 1'b0;
            sec_tick_q <= 1'b0;
        end else begin
            min_q      <= min_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            presc_q    <= presc_d;
            time_up_q  <= time_up_d;
            warn_q     <= warn_d;
            sec_tick_q <= sec_tick_d;
        end
    end

    assign tmr.time_up  = time_up_q;
    assign tmr.warn     = warn_q;
    assign tmr.sec_tick = sec_tick_q;
    assign tmr.min_bcd  = min_q;
    assign tmr.sec_tens = tens_q;
    assign tmr.sec_ones = ones_q;

endmodule

// File: tb/tb_match_timer.sv
// Directed bench: a 12-second timer for the main scenarios and a 100-second timer
// for the minute borrow chain, both with 4 clocks per game second.
module tb_match_timer;

    localparam logic [2:0] STATE_READY   = 3'd0;
    localparam logic [2:0] STATE_GAME    = 3'd1;
    localparam logic [2:0] STATE_P1_WINS = 3'd2;
    localparam logic [2:0] STATE_1P_GAME = 3'd4;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    match_timer_if a_if ();
    match_timer_if b_if ();

    match_timer #(.CLK_HZ(4), .MATCH_SEC(12), .WARN_SEC(10)) u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .tmr (a_if.slave)
    );

    match_timer #(.CLK_HZ(4), .MATCH_SEC(100), .WARN_SEC(10)) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .tmr (b_if.slave)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int bcd_of(input int s);
        return ((s / 60) << 8) | (((s % 60) / 10) << 4) | (s % 10);
    endfunction

    function automatic int digits_a();
        return {20'd0, a_if.min_bcd, a_if.sec_tens, a_if.sec_ones};
    endfunction

    function automatic int digits_b();
        return {20'd0, b_if.min_bcd, b_if.sec_tens, b_if.sec_ones};
    endfunction

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        a_if.state = STATE_READY;
        a_if.pause = 1'b0;
        b_if.state = STATE_READY;
        b_if.pause = 1'b0;
        step(2);
        rst_a = 1'b0;
        step(1);
        check("reset_digits", digits_a(), 'h012);
        check("reset_time_up", a_if.time_up, 0);
        check("reset_warn", a_if.warn, 0);
        check("reset_tick", a_if.sec_tick, 0);

        // Full 12-second countdown, 4 cycles per second
        a_if.state = STATE_GAME;
        for (int c = 1; c <= 48; c++) begin
            int s;
            step(1);
            s = 12 - c / 4;
            check($sformatf("run_tick_c%0d", c), a_if.sec_tick, (c % 4 == 0) ? 1 : 0);
            check($sformatf("run_digits_c%0d", c), digits_a(), bcd_of(s));
            check($sformatf("run_warn_c%0d", c), a_if.warn, (s <= 10) ? 1 : 0);
            check($sformatf("run_time_up_c%0d", c), a_if.time_up, (c == 48) ? 1 : 0);
        end
        for (int c = 0; c < 20; c++) begin
            step(1);
            check("hold_time_up", a_if.time_up, 1);
            check("hold_digits", digits_a(), 'h000);
            check("hold_tick", a_if.sec_tick, 0);
        end

        // Pause from prescaler=2: the partial second resumes after pause drops
        a_if.state = STATE_READY;
        step(1);
        check("reload_digits", digits_a(), 'h012);
        check("reload_time_up", a_if.time_up, 0);
        a_if.state = STATE_GAME;
        step(2);
        a_if.pause = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step(1);
            check("pause_digits", digits_a(), 'h012);
            check("pause_tick", a_if.sec_tick, 0);
        end
        a_if.pause = 1'b0;
        step(1);
        check("unpause_c1_tick", a_if.sec_tick, 0);
        step(1);
        check("unpause_c2_tick", a_if.sec_tick, 1);
        check("unpause_c2_digits", digits_a(), 'h011);

        // Count to 0:07, then freeze on the cycle a tick is due
        step(16);
        check("at_007_digits", digits_a(), 'h007);
        check("at_007_warn", a_if.warn, 1);
        step(3);
        a_if.state = STATE_P1_WINS;
        step(1);
        check("freeze_digits", digits_a(), 'h007);
        check("freeze_tick", a_if.sec_tick, 0);
        check("freeze_warn", a_if.warn, 0);
        step(5);
        check("freeze_hold_digits", digits_a(), 'h007);
        check("freeze_time_up", a_if.time_up, 0);
        a_if.state = STATE_READY;
        step(1);
        check("ready_digits", digits_a(), 'h012);
        check("ready_warn", a_if.warn, 0);
        a_if.state = STATE_1P_GAME;
        step(1);
        check("1p_first_time_up", a_if.time_up, 0);
        check("1p_first_digits", digits_a(), 'h012);
        step(3);
        check("1p_tick", a_if.sec_tick, 1);
        check("1p_digits", digits_a(), 'h011);

        // Direct 1P -> 2P switch keeps counting without reload
        a_if.state = STATE_GAME;
        step(4);
        check("switch_digits", digits_a(), 'h010);
        check("switch_tick", a_if.sec_tick, 1);

        // Mid-count reset at 0:05 with a partial second pending
        step(20);
        check("pre_rst_digits", digits_a(), 'h005);
        step(2);
        rst_a = 1'b1;
        step(1);
        rst_a = 1'b0;
        check("rst_digits", digits_a(), 'h012);
        check("rst_time_up", a_if.time_up, 0);
        check("rst_warn", a_if.warn, 0);
        check("rst_tick", a_if.sec_tick, 0);
        step(3);
        check("rst_presc_no_tick", a_if.sec_tick, 0);
        step(1);
        check("rst_presc_tick", a_if.sec_tick, 1);
        check("rst_presc_digits", digits_a(), 'h011);

        // 100-second match: minute borrow chain down to 0:00
        rst_b = 1'b0;
        step(1);
        check("b_reset_digits", digits_b(), 'h140);
        b_if.state = STATE_GAME;
        for (int t = 1; t <= 100; t++) begin
            step(4);
            check($sformatf("b_tick_t%0d", t), b_if.sec_tick, 1);
            check($sformatf("b_digits_t%0d", t), digits_b(), bcd_of(100 - t));
            check($sformatf("b_time_up_t%0d", t), b_if.time_up, (t == 100) ? 1 : 0);
        end
        check("b_borrow_reference", bcd_of(100 - 41), 'h059);
        step(8);
        check("b_end_digits", digits_b(), 'h000);
        check("b_end_tick", b_if.sec_tick, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
